// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - BCD countdown timer with start/pause/clear/load control and patterned expiry buzzer
// Optional build macro: TIMER_ALARM_LATCH_EN (buzzer keeps sounding until clear or start).
module countdown_timer_bcd #(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          DIGITS     = 2,
    parameter logic [15:0] PRESET     = 16'h0030,
    parameter int          BUZZ_HALF  = 12_500_000,
    parameter int          BUZZ_BEEPS = 3
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  running,
    output logic                  expired,
    output logic                  buzzer,
    output logic                  tick
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
    localparam logic [W-1:0]  PRESET_V = PRESET[W-1:0];
    localparam logic [PW-1:0] P_TERM   = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] B_TERM   = BW'(BUZZ_HALF - 1);
    localparam logic [3:0]    BEEP_END = 4'(BUZZ_BEEPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_BUZZ, S_DONE} state_t;

    state_t         state;
    logic [PW-1:0]  presc;
    logic [BW-1:0]  buzz_cnt;
    logic [3:0]     beep_cnt;
    logic [W-1:0]   reload;
    logic [W-1:0]   bcd_next;

    // Ripple-borrow BCD decrement: a zero digit wraps to 9 and keeps borrowing.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign bcd_next = bcd_dec(bcd_out);
    assign running  = (state == S_RUN);
    assign expired  = (state == S_BUZZ) || (state == S_DONE);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_IDLE;
            bcd_out  <= PRESET_V;
            reload   <= PRESET_V;
            presc    <= '0;
            buzz_cnt <= '0;
            beep_cnt <= '0;
            buzzer   <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                state    <= S_IDLE;
                bcd_out  <= PRESET_V;
                reload   <= PRESET_V;
                presc    <= '0;
                buzz_cnt <= '0;
                beep_cnt <= '0;
                buzzer   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (load) begin
                            bcd_out <= load_val;
                            reload  <= load_val;
                        end else if (start) begin
                            presc <= '0;
                            if (bcd_out == '0) begin
                                state    <= S_BUZZ;
                                buzzer   <= 1'b1;
                                buzz_cnt <= '0;
                                beep_cnt <= '0;
                            end else begin
                                state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        // start outranks pause, so a coincident pair keeps counting
                        if (pause && !start) begin
                            state <= S_PAUSE;
                        end else if (presc == P_TERM) begin
                            presc   <= '0;
                            tick    <= 1'b1;
                            bcd_out <= bcd_next;
                            if (bcd_next == '0) begin
                                state    <= S_BUZZ;
                                buzzer   <= 1'b1;
                                buzz_cnt <= '0;
                                beep_cnt <= '0;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (load) begin
                            bcd_out <= load_val;
                            reload  <= load_val;
                            presc   <= '0;
                        end else if (start) begin
                            state <= S_RUN;
                        end
                    end
                    S_BUZZ: begin
`ifdef TIMER_ALARM_LATCH_EN
                        if (start) begin
                            state    <= S_RUN;
                            bcd_out  <= reload;
                            presc    <= '0;
                            buzzer   <= 1'b0;
                            buzz_cnt <= '0;
                        end else if (buzz_cnt == B_TERM) begin
                            buzz_cnt <= '0;
                            buzzer   <= ~buzzer;
                        end else begin
                            buzz_cnt <= buzz_cnt + 1'b1;
                        end
`else
                        if (buzz_cnt == B_TERM) begin
                            buzz_cnt <= '0;
                            if (buzzer) begin
                                buzzer <= 1'b0;
                            end else if (beep_cnt == BEEP_END) begin
                                state <= S_DONE;
                            end else begin
                                buzzer   <= 1'b1;
                                beep_cnt <= beep_cnt + 1'b1;
                            end
                        end else begin
                            buzz_cnt <= buzz_cnt + 1'b1;
                        end
`endif
                    end
                    S_DONE: begin
                        if (load) begin
                            bcd_out <= load_val;
                            reload  <= load_val;
                        end else if (start) begin
                            state   <= S_RUN;
                            bcd_out <= reload;
                            presc   <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb/tb_countdown_timer_bcd.sv - self-checking bench: directed timing checks plus random control against a behavioural model
module tb_countdown_timer_bcd;
    localparam int          HZ     = 10;
    localparam int          DIG    = 2;
    localparam logic [15:0] PRE    = 16'h0003;
    localparam int          BH     = 4;
    localparam int          BB     = 3;
    localparam int          MAXV   = 100;
    localparam int          PREV   = 3;

    logic           CLK = 1'b0;
    logic           RSTn = 1'b0;
    logic           start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0;
    logic [4*DIG-1:0] load_val = '0;
    logic [4*DIG-1:0] bcd_out;
    logic           running, expired, buzzer, tick;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model: 0 idle, 1 run, 2 pause, 3 buzz, 4 done
    int m_st, m_cnt, m_presc, m_el, m_reload;
    bit m_tick;

    countdown_timer_bcd #(.CLK_HZ(HZ), .DIGITS(DIG), .PRESET(PRE), .BUZZ_HALF(BH), .BUZZ_BEEPS(BB)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .pause(pause), .clear(clear), .load(load),
        .load_val(load_val), .bcd_out(bcd_out), .running(running), .expired(expired),
        .buzzer(buzzer), .tick(tick)
    );

    always #5 CLK = ~CLK;

    function automatic logic [4*DIG-1:0] to_bcd(input int v);
        logic [4*DIG-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < DIG; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [4*DIG-1:0] b);
        int v, p;
        v = 0;
        p = 1;
        for (int d = 0; d < DIG; d++) begin
            v = v + int'(b[4*d +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = PREV; m_presc = 0; m_el = 0; m_reload = PREV; m_tick = 0;
    endtask

    task automatic model_adv(input bit c, input bit l, input bit s, input bit p, input logic [4*DIG-1:0] lv);
        int lvn;
        lvn = from_bcd(lv);
        m_tick = 0;
        if (c) begin
            model_reset();
        end else begin
            case (m_st)
                0: if (l) begin m_cnt = lvn; m_reload = lvn; end
                   else if (s) begin m_presc = 0; if (m_cnt != 0) m_st = 1; else begin m_st = 3; m_el = 0; end end
                1: if (p && !s) m_st = 2;
                   else if (m_presc == HZ - 1) begin
                       m_presc = 0; m_tick = 1;
                       m_cnt = (m_cnt == 0) ? MAXV - 1 : m_cnt - 1;
                       if (m_cnt == 0) begin m_st = 3; m_el = 0; end
                   end else m_presc++;
                2: if (l) begin m_cnt = lvn; m_reload = lvn; m_presc = 0; end
                   else if (s) m_st = 1;
                3: begin
`ifdef TIMER_ALARM_LATCH_EN
                    if (s) begin m_st = 1; m_cnt = m_reload; m_presc = 0; end
                    else m_el++;
`else
                    m_el++;
                    if (m_el == 2 * BH * BB) m_st = 4;
`endif
                end
                default: if (l) begin m_cnt = lvn; m_reload = lvn; end
                         else if (s) begin m_st = 1; m_cnt = m_reload; m_presc = 0; end
            endcase
        end
    endtask

    task automatic cyc(input bit c, input bit l, input bit s, input bit p, input logic [4*DIG-1:0] lv);
        clear = c; load = l; start = s; pause = p; load_val = lv;
        @(posedge CLK);
        #1;
        model_adv(c, l, s, p, lv);
        clear = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0);
    endtask

    always @(negedge CLK) begin
        if (chk_en && RSTn) begin
            chk("bcd_out", 32'(bcd_out), 32'(to_bcd(m_cnt)));
            chk("running", 32'(running), 32'(m_st == 1));
            chk("expired", 32'(expired), 32'(m_st == 3 || m_st == 4));
            chk("buzzer",  32'(buzzer),  32'(m_st == 3 && ((m_el / BH) % 2 == 0)));
            chk("tick",    32'(tick),    32'(m_tick));
        end
    end

    initial begin
        int ticks_early, hi;
        bit c, l, s, p;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_bcd", 32'(bcd_out), 32'h03);
        chk("rst_flags", {28'd0, running, expired, buzzer, tick}, 32'd0);
        RSTn = 1'b1;
        #1 chk_en = 1'b1;

        // first tick ten cycles after start, then expiry on the third
        cyc(0, 0, 1, 0, '0);
        ticks_early = 0;
        for (int n = 1; n < 10; n++) begin
            cyc(0, 0, 0, 0, '0);
            if (tick) ticks_early++;
        end
        chk("no_early_tick", ticks_early, 0);
        cyc(0, 0, 0, 0, '0);
        chk("tick_at_10", 32'(tick), 32'd1);
        chk("bcd_after_1", 32'(bcd_out), 32'h02);
        idle(20);
        chk("expiry_bcd", 32'(bcd_out), 32'h00);
        chk("expiry_flags", {29'd0, running, expired, buzzer}, 32'b011);

        hi = 0;
        for (int i = 0; i < 2 * BH * BB; i++) begin
            if (buzzer) hi++;
            cyc(0, 0, 0, 0, '0);
        end
        chk("buzz_high_cycles", hi, 12);
        chk("done_flags", {29'd0, running, expired, buzzer}, 32'b010);

        // borrow across digits
        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, 8'h10);
        chk("load_idle", 32'(bcd_out), 32'h10);
        cyc(0, 0, 1, 0, '0);
        idle(10);
        chk("borrow_bcd", 32'(bcd_out), 32'h09);

        // pause with prescaler at 6; resume needs 4 more cycles
        idle(6);
        cyc(0, 0, 0, 1, '0);
        chk("paused_running", 32'(running), 32'd0);
        idle(20);
        chk("pause_hold_bcd", 32'(bcd_out), 32'h09);
        cyc(0, 0, 1, 0, '0);
        idle(3);
        chk("resume_no_tick", 32'(tick), 32'd0);
        idle(1);
        chk("resume_tick", 32'(tick), 32'd1);
        chk("resume_bcd", 32'(bcd_out), 32'h08);

        cyc(1, 0, 1, 0, '0);
        chk("clear_start_bcd", 32'(bcd_out), 32'h03);
        chk("clear_start_run", 32'(running), 32'd0);

        // async reset in the middle of the buzz phase
        cyc(0, 0, 1, 0, '0);
        idle(32);
        chk("pre_rst_buzzer", 32'(buzzer), 32'd1);
        #1 RSTn = 1'b0;
        #1;
        chk("async_rst_buzzer", 32'(buzzer), 32'd0);
        chk("async_rst_expired", 32'(expired), 32'd0);
        chk("async_rst_bcd", 32'(bcd_out), 32'h03);
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;

        for (int i = 0; i < 8000; i++) begin
            c = ($urandom_range(0, 299) == 0);
            l = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 14) == 0);
            p = ($urandom_range(0, 24) == 0);
            cyc(c, l, s, p, to_bcd($urandom_range(0, 25)));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
Parametrised BCD countdown timer with start/pause/clear/load control and a patterned buzzer output at expiry. It runs entirely in the CLK domain and uses one-cycle enable ticks; there are no derived clocks. The digit outputs feed the seven-segment display driver, and the buzzer output drives the board buzzer pin.

Parameters:
CLK_HZ, 50_000_000, CLK frequency; the prescaler produces one count tick every CLK_HZ cycles (1 s).
DIGITS, 2, number of BCD digits; legal range 1..4.
PRESET, 16'h0030, BCD reset/reload value (4*DIGITS LSBs used); every nibble must be 0..9.
BUZZ_HALF, 12_500_000, CLK cycles per buzzer half-period (2 Hz tone at 50 MHz).
BUZZ_BEEPS, 3, number of full buzzer on/off periods emitted at expiry; must be 1..15.

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin or resume counting
pause  input  1  one-cycle pulse; freeze count
clear  input  1  one-cycle pulse; return to IDLE with PRESET
load  input  1  one-cycle pulse; capture load_val (IDLE/PAUSE/DONE only)
load_val  input  4*DIGITS  BCD value to load
bcd_out  output  4*DIGITS  current count; digit 0 in LSBs
running  output  1  high in RUN
expired  output  1  high in BUZZ and DONE
buzzer  output  1  buzzer drive
tick  output  1  one-cycle pulse on each count decrement

Behaviour:
- Reset (async, RSTn=0): state IDLE, bcd_out=PRESET, prescaler=0, buzzer=0, running=0, expired=0, tick=0.
- States: IDLE, RUN, PAUSE, BUZZ, DONE. All transitions are registered and take effect on the next CLK edge.
- Control priority when pulses coincide: clear > load > start > pause.
- IDLE:
  - start with bcd_out != 0 -> RUN.
  - start with bcd_out == 0 -> BUZZ immediately.
  - load -> bcd_out=load_val; state unchanged.
- RUN:
  - Prescaler counts 0..CLK_HZ-1. On the terminal value, tick=1 for one cycle and bcd_out decrements.
  - Decrement is BCD with borrow. A digit at 0 wraps to 9 and borrows from the next digit. Example: 0x40 -> 0x39.
  - If the decrement result is 0, go to BUZZ on the same edge.
  - pause -> PAUSE; prescaler holds its value. load is ignored in RUN.
- PAUSE:
  - start -> RUN; prescaler resumes from the held value.
  - load -> bcd_out=load_val and prescaler=0.
- BUZZ:
  - buzzer toggles every BUZZ_HALF cycles, starting high on BUZZ entry.
  - After BUZZ_BEEPS high/low periods, buzzer=0 and state -> DONE.
  - start and pause are ignored.
- DONE:
  - bcd_out holds 0; expired=1.
  - start -> bcd_out=PRESET (or the last loaded value, if load occurred since clear) and state -> RUN.
  - load -> bcd_out=load_val; state stays DONE.
- clear in any state -> IDLE, bcd_out=PRESET, prescaler=0, buzzer=0, beep counter=0, reload register=PRESET.
- Illegal BCD nibbles on load_val are captured unchanged; behaviour is undefined until the next clear/load.
- Prescaler width is $clog2(CLK_HZ). Buzzer counter width is $clog2(BUZZ_HALF). Beep counter is 4 bits.
- tick is asserted only in RUN.

Optional Feature:
Macro TIMER_ALARM_LATCH_EN.
- Defined: BUZZ does not end after BUZZ_BEEPS. The buzzer keeps toggling until clear or start. start in BUZZ reloads the reload register and enters RUN.
- Undefined: behaviour exactly as specified above.

Test Plan:
- CLK_HZ=10, PRESET=0x03; reset, start -> tick every 10 cycles; bcd_out 03,02,01,00; BUZZ entered on the edge bcd_out becomes 00; running drops the same cycle.
- DIGITS=2, load 0x10 in IDLE, start -> after one tick bcd_out=0x09 (borrow check); after 9 more ticks bcd_out=0x00 and expired=1.
- BUZZ_HALF=4, BUZZ_BEEPS=3 -> buzzer high 4 / low 4, repeated 3 times (24 cycles); then DONE with buzzer=0 and expired=1.
- RUN with prescaler at 6, pause for 20 cycles, start -> next tick arrives 4 cycles after resume; bcd_out unchanged during pause.
- Same-cycle clear+start in RUN -> IDLE, bcd_out=PRESET; RSTn asserted mid-BUZZ -> buzzer=0 and state IDLE asynchronously.
- With TIMER_ALARM_LATCH_EN: expiry, wait 100 half-periods -> buzzer still toggling; start -> RUN with reloaded value and buzzer=0.
